mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multi-cycle sequencer for the MIPS datapath (NPC/PC/IM/GRF/EXT/ALU/DM). It replaces single-cycle combinational control.
- It takes the instruction held in an external IR and steps each instruction through FETCH/DECODE/EXEC/MEM/WB, one state per cycle.
- In each state it asserts the write enables and mux selects for the datapath.
- PC is written only in an instruction's last state, so PC and PC4 stay stable for the whole instruction.

Parameters:
- STATE_W, 3, width of the state register and state output.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- ins  input  32  instruction from IR (valid from DECODE onward).
- is_equal  input  1  ALU equality flag, used by beq.
- ir_we  output  1  IR load enable.
- pc_we  output  1  PC load enable.
- npc_sel  output  2  00 PC+4, 01 branch target, 10 jal target, 11 rs (jr).
- grf_we  output  1  register file write enable.
- a3_sel  output  2  00 rd, 01 rt, 10 $31.
- wd_sel  output  2  00 ALU C, 01 DM RD, 10 PC4.
- alu_b_sel  output  1  0 RD2, 1 extended imm.
- ext_signed  output  1  1 sign-extend, 0 zero-extend.
- alu_op  output  3  000 add, 001 sub, 010 or, 011 lui (B<<16).
- dm_we  output  1  data memory write enable.
- state  output  STATE_W  current state.
- ins_done  output  1  one-cycle pulse in an instruction's final state.
- illegal  output  1  high in DECODE for unsupported encodings.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Values 5-7 return to FETCH on the next edge.
- Reset:
  - reset=0 forces state=FETCH immediately, independent of clk.
  - Reset mid-instruction abandons it. No partial GRF/DM write occurs after reset asserts.
- Outputs:
  - All outputs are combinational from (state, ins, is_equal).
  - Any output not listed for a state is 0.
  - In reset/FETCH: ir_we=1 and every other enable is 0.
- FETCH: ir_we=1 -> DECODE.
- DECODE:
  - Decodes op=ins[31:26], funct=ins[5:0].
  - jal -> WB. Every other supported instruction -> EXEC.
  - Unsupported encoding: illegal=1, pc_we=1, npc_sel=00, ins_done=1 -> FETCH (executes as nop).
- EXEC:
  - add/sub (op 0, funct 100000/100010): alu_b_sel=0, alu_op=000/001 -> WB.
  - ori (001101): alu_b_sel=1, ext_signed=0, alu_op=010 -> WB.
  - lui (001111): alu_b_sel=1, alu_op=011 -> WB.
  - lw/sw (100011/101011): alu_b_sel=1, ext_signed=1, alu_op=000 -> MEM.
  - beq (000100): alu_op=001, pc_we=1, npc_sel = is_equal?01:00, ins_done=1 -> FETCH.
  - jr (op 0, funct 001000): pc_we=1, npc_sel=11, ins_done=1 -> FETCH.
  - nop (all zero) is sll $0 and is accepted as an R-type with no write: pc_we=1, npc_sel=00, ins_done=1 -> FETCH.
- MEM: ALU operand selects stay at their EXEC values.
  - lw -> WB.
  - sw: dm_we=1, pc_we=1, npc_sel=00, ins_done=1 -> FETCH.
- WB: grf_we=1, pc_we=1, ins_done=1 -> FETCH. Per instruction:
  - add/sub: a3_sel=00, wd_sel=00, npc_sel=00, ALU selects held.
  - ori/lui: a3_sel=01, wd_sel=00, npc_sel=00, ALU selects held.
  - lw: a3_sel=01, wd_sel=01, npc_sel=00.
  - jal: a3_sel=10, wd_sel=10, npc_sel=10.
- CPI: beq/jr/nop 3, jal 3, sw 4, R/ori/lui 4, lw 5.
- ins_done marks exactly one cycle per instruction, coincident with pc_we.

Optional Feature:
- Macro MC_MEM_WAIT_EN.
- Enabled:
  - Adds input mem_ready (1 bit).
  - MEM holds while mem_ready=0. dm_we (sw) stays asserted every MEM cycle.
  - pc_we and ins_done for sw are gated by mem_ready.
  - lw leaves MEM only when mem_ready=1.
  - Reset while waiting returns to FETCH.
- Disabled: no mem_ready port; MEM always lasts exactly one cycle.

Test Plan:
- Reset release: reset=0 mid-EXEC of add -> state=0 immediately, grf_we=0; after reset=1, first edge goes to DECODE.
- ins=0x00221820 (add $3,$1,$2) -> states 0,1,2,4; in WB grf_we=1, a3_sel=00, wd_sel=00, pc_we=1, npc_sel=00.
- ins=0x8C220004 (lw) -> 5 cycles; MEM has dm_we=0; WB has wd_sel=01, a3_sel=01; ins_done high only in WB.
- ins=0x10220003 (beq), is_equal=1 -> EXEC npc_sel=01, pc_we=1; with is_equal=0 -> npc_sel=00; 3 cycles.
- ins=0x0C000C00 (jal) -> states 0,1,4; WB a3_sel=10, wd_sel=10, npc_sel=10. ins=0x03E00008 (jr $31) -> EXEC npc_sel=11.
- ins=0xFC000000 -> DECODE illegal=1, pc_we=1, npc_sel=00, next state FETCH. With MC_MEM_WAIT_EN, sw holding mem_ready=0 for 3 cycles -> dm_we=1 for 4 MEM cycles, pc_we only on the mem_ready=1 cycle.

Source files
------------

// File: rtl/mc_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS datapath.
// Define MC_MEM_WAIT_EN to add a mem_ready handshake that stretches the MEM state.
module mc_controller #(
    parameter int STATE_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        ins,
    input  logic               is_equal,
`ifdef MC_MEM_WAIT_EN
    input  logic               mem_ready,
`endif
    output logic               ir_we,
    output logic               pc_we,
    output logic [1:0]         npc_sel,
    output logic               grf_we,
    output logic [1:0]         a3_sel,
    output logic [1:0]         wd_sel,
    output logic               alu_b_sel,
    output logic               ext_signed,
    output logic [2:0]         alu_op,
    output logic               dm_we,
    output logic [STATE_W-1:0] state,
    output logic               ins_done,
    output logic               illegal
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = STATE_W'(0),
        S_DECODE = STATE_W'(1),
        S_EXEC   = STATE_W'(2),
        S_MEM    = STATE_W'(3),
        S_WB     = STATE_W'(4)
    } state_t;

    typedef enum logic [3:0] {
        K_ADD, K_SUB, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_JAL, K_JR, K_NOP, K_ILL
    } kind_t;

    state_t     state_q;
    kind_t      kind;
    logic       mem_go;
    logic       k_b_sel;
    logic       k_signed;
    logic [2:0] k_alu_op;

`ifdef MC_MEM_WAIT_EN
    assign mem_go = mem_ready;
`else
    assign mem_go = 1'b1;
`endif

    assign state = state_q;

    // Only the all-zero sll is accepted; any other shift encoding is illegal.
    always_comb begin
        kind = K_ILL;
        case (ins[31:26])
            6'b000000: begin
                if (ins == 32'd0)               kind = K_NOP;
                else if (ins[5:0] == 6'b100000) kind = K_ADD;
                else if (ins[5:0] == 6'b100010) kind = K_SUB;
                else if (ins[5:0] == 6'b001000) kind = K_JR;
                else                            kind = K_ILL;
            end
            6'b001101: kind = K_ORI;
            6'b001111: kind = K_LUI;
            6'b100011: kind = K_LW;
            6'b101011: kind = K_SW;
            6'b000100: kind = K_BEQ;
            6'b000011: kind = K_JAL;
            default:   kind = K_ILL;
        endcase
    end

    always_comb begin
        k_b_sel  = 1'b0;
        k_signed = 1'b0;
        k_alu_op = 3'b000;
        case (kind)
            K_SUB:      k_alu_op = 3'b001;
            K_ORI:      begin k_b_sel = 1'b1; k_alu_op = 3'b010; end
            K_LUI:      begin k_b_sel = 1'b1; k_alu_op = 3'b011; end
            K_LW, K_SW: begin k_b_sel = 1'b1; k_signed = 1'b1; end
            K_BEQ:      k_alu_op = 3'b001;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  state_q <= S_DECODE;
                S_DECODE: begin
                    if (kind == K_ILL)      state_q <= S_FETCH;
                    else if (kind == K_JAL) state_q <= S_WB;
                    else                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    case (kind)
                        K_LW, K_SW:               state_q <= S_MEM;
                        K_ADD, K_SUB, K_ORI, K_LUI: state_q <= S_WB;
                        default:                  state_q <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (!mem_go && (kind == K_LW || kind == K_SW)) state_q <= S_MEM;
                    else if (kind == K_LW)                         state_q <= S_WB;
                    else                                           state_q <= S_FETCH;
                end
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    // PC is only ever loaded in the instruction's final state, together with ins_done.
    always_comb begin
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        npc_sel    = 2'b00;
        grf_we     = 1'b0;
        a3_sel     = 2'b00;
        wd_sel     = 2'b00;
        alu_b_sel  = 1'b0;
        ext_signed = 1'b0;
        alu_op     = 3'b000;
        dm_we      = 1'b0;
        ins_done   = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: ir_we = 1'b1;
            S_DECODE: begin
                if (kind == K_ILL) begin
                    illegal  = 1'b1;
                    pc_we    = 1'b1;
                    ins_done = 1'b1;
                end
            end
            S_EXEC: begin
                alu_b_sel  = k_b_sel;
                ext_signed = k_signed;
                alu_op     = k_alu_op;
                case (kind)
                    K_BEQ: begin
                        pc_we    = 1'b1;
                        npc_sel  = is_equal ? 2'b01 : 2'b00;
                        ins_done = 1'b1;
                    end
                    K_JR:  begin pc_we = 1'b1; npc_sel = 2'b11; ins_done = 1'b1; end
                    K_NOP: begin pc_we = 1'b1; ins_done = 1'b1; end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (kind == K_LW || kind == K_SW) begin
                    alu_b_sel  = k_b_sel;
                    ext_signed = k_signed;
                    alu_op     = k_alu_op;
                end
                if (kind == K_SW) begin
                    dm_we    = 1'b1;
                    pc_we    = mem_go;
                    ins_done = mem_go;
                end
            end
            S_WB: begin
                case (kind)
                    K_ADD, K_SUB, K_ORI, K_LUI: begin
                        grf_we     = 1'b1;
                        pc_we      = 1'b1;
                        ins_done   = 1'b1;
                        a3_sel     = (kind == K_ORI || kind == K_LUI) ? 2'b01 : 2'b00;
                        alu_b_sel  = k_b_sel;
                        ext_signed = k_signed;
                        alu_op     = k_alu_op;
                    end
                    K_LW:  begin
                        grf_we = 1'b1; pc_we = 1'b1; ins_done = 1'b1;
                        a3_sel = 2'b01; wd_sel = 2'b01;
                    end
                    K_JAL: begin
                        grf_we = 1'b1; pc_we = 1'b1; ins_done = 1'b1;
                        a3_sel = 2'b10; wd_sel = 2'b10; npc_sel = 2'b10;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-cycle expected control vectors are queued
// per instruction and compared at the falling edge. Covers MC_MEM_WAIT_EN when defined.
module tb_mc_controller;

    typedef struct packed {
        logic [2:0] state;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] npc_sel;
        logic       grf_we;
        logic [1:0] a3_sel;
        logic [1:0] wd_sel;
        logic       alu_b_sel;
        logic       ext_signed;
        logic [2:0] alu_op;
        logic       dm_we;
        logic       ins_done;
        logic       illegal;
    } obs_t;

    typedef struct packed {
        obs_t exp;
        logic ready;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ins = 32'd0;
    logic        is_equal = 1'b0;
`ifdef MC_MEM_WAIT_EN
    logic        mem_ready = 1'b1;
`endif
    logic        ir_we, pc_we, grf_we, alu_b_sel, ext_signed, dm_we, ins_done, illegal;
    logic [1:0]  npc_sel, a3_sel, wd_sel;
    logic [2:0]  alu_op;
    logic [2:0]  state;
    obs_t        cur;

    entry_t sb[$];
    int compared = 0;
    int mismatched = 0;

    mc_controller #(.STATE_W(3)) dut (
        .clk(clk), .reset(reset), .ins(ins), .is_equal(is_equal),
`ifdef MC_MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .ir_we(ir_we), .pc_we(pc_we), .npc_sel(npc_sel), .grf_we(grf_we),
        .a3_sel(a3_sel), .wd_sel(wd_sel), .alu_b_sel(alu_b_sel),
        .ext_signed(ext_signed), .alu_op(alu_op), .dm_we(dm_we),
        .state(state), .ins_done(ins_done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign cur = {state, ir_we, pc_we, npc_sel, grf_we, a3_sel, wd_sel,
                  alu_b_sel, ext_signed, alu_op, dm_we, ins_done, illegal};

    // Expected vector; ir_we is high exactly in FETCH.
    function automatic obs_t mk(input int s, input int pc, input int npc, input int grf,
                                input int a3, input int wd, input int bsel, input int sx,
                                input int op, input int dmwe, input int done, input int ill);
        obs_t o;
        o.state      = 3'(s);
        o.ir_we      = (s == 0);
        o.pc_we      = 1'(pc);
        o.npc_sel    = 2'(npc);
        o.grf_we     = 1'(grf);
        o.a3_sel     = 2'(a3);
        o.wd_sel     = 2'(wd);
        o.alu_b_sel  = 1'(bsel);
        o.ext_signed = 1'(sx);
        o.alu_op     = 3'(op);
        o.dm_we      = 1'(dmwe);
        o.ins_done   = 1'(done);
        o.illegal    = 1'(ill);
        return o;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%05h expected 0x%05h", tag, observed, expected);
        end
    endtask

    task automatic push(input obs_t o, input logic rdy);
        entry_t e;
        e.exp   = o;
        e.ready = rdy;
        sb.push_back(e);
    endtask

    // Pops one expectation per cycle; starts just after a rising edge with state=FETCH.
    task automatic drainQueue(input string tag);
        entry_t e;
        int n = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
`ifdef MC_MEM_WAIT_EN
            mem_ready = e.ready;
`endif
            @(negedge clk);
            checkOutput($sformatf("%s.c%0d", tag, n), 32'(cur), 32'(e.exp));
            n++;
            @(posedge clk);
            #1;
        end
`ifdef MC_MEM_WAIT_EN
        mem_ready = 1'b1;
`endif
    endtask

    task automatic applyStimulus(input string name, input logic [31:0] i, input logic eq,
                                 input int waits);
        ins      = i;
        is_equal = eq;
        push(mk(0, 0,0,0,0,0,0,0,0,0,0,0), 1'b1);
        if (name == "ill") begin
            push(mk(1, 1,0,0,0,0,0,0,0,0,1,1), 1'b1);
        end else begin
            push(mk(1, 0,0,0,0,0,0,0,0,0,0,0), 1'b1);
        end
        if (name == "add") begin
            push(mk(2, 0,0,0,0,0,0,0,0,0,0,0), 1'b1);
            push(mk(4, 1,0,1,0,0,0,0,0,0,1,0), 1'b1);
        end else if (name == "sub") begin
            push(mk(2, 0,0,0,0,0,0,0,1,0,0,0), 1'b1);
            push(mk(4, 1,0,1,0,0,0,0,1,0,1,0), 1'b1);
        end else if (name == "ori") begin
            push(mk(2, 0,0,0,0,0,1,0,2,0,0,0), 1'b1);
            push(mk(4, 1,0,1,1,0,1,0,2,0,1,0), 1'b1);
        end else if (name == "lui") begin
            push(mk(2, 0,0,0,0,0,1,0,3,0,0,0), 1'b1);
            push(mk(4, 1,0,1,1,0,1,0,3,0,1,0), 1'b1);
        end else if (name == "lw") begin
            push(mk(2, 0,0,0,0,0,1,1,0,0,0,0), 1'b1);
            for (int k = 0; k < waits; k++) push(mk(3, 0,0,0,0,0,1,1,0,0,0,0), 1'b0);
            push(mk(3, 0,0,0,0,0,1,1,0,0,0,0), 1'b1);
            push(mk(4, 1,0,1,1,1,0,0,0,0,1,0), 1'b1);
        end else if (name == "sw") begin
            push(mk(2, 0,0,0,0,0,1,1,0,0,0,0), 1'b1);
            for (int k = 0; k < waits; k++) push(mk(3, 0,0,0,0,0,1,1,0,1,0,0), 1'b0);
            push(mk(3, 1,0,0,0,0,1,1,0,1,1,0), 1'b1);
        end else if (name == "beq") begin
            push(mk(2, 1,(eq ? 1 : 0),0,0,0,0,0,1,0,1,0), 1'b1);
        end else if (name == "jal") begin
            push(mk(4, 1,2,1,2,2,0,0,0,0,1,0), 1'b1);
        end else if (name == "jr") begin
            push(mk(2, 1,3,0,0,0,0,0,0,0,1,0), 1'b1);
        end else if (name == "nop") begin
            push(mk(2, 1,0,0,0,0,0,0,0,0,1,0), 1'b1);
        end
        drainQueue(name);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        ins = 32'h0022_1820;
        #3;
        checkOutput("rst.async", 32'(cur), 32'(mk(0, 0,0,0,0,0,0,0,0,0,0,0)));
        @(posedge clk);
        #1;
        checkOutput("rst.held", 32'(cur), 32'(mk(0, 0,0,0,0,0,0,0,0,0,0,0)));
        reset = 1'b1;

        applyStimulus("add", 32'h0022_1820, 1'b0, 0);

        // Abandon an add in EXEC: reset must drop to FETCH before any clock edge.
        ins = 32'h0022_1820;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("midrst.exec", 32'(state), 32'd2);
        reset = 1'b0;
        #1;
        checkOutput("midrst.async", 32'(cur), 32'(mk(0, 0,0,0,0,0,0,0,0,0,0,0)));
        @(posedge clk);
        #1;
        checkOutput("midrst.grf_we", 32'(grf_we), 32'd0);
        reset = 1'b1;

        applyStimulus("add", 32'h0022_1820, 1'b0, 0);
        applyStimulus("sub", 32'h0022_1822, 1'b0, 0);
        applyStimulus("ori", 32'h3422_1234, 1'b0, 0);
        applyStimulus("lui", 32'h3C02_1234, 1'b0, 0);
        applyStimulus("lw",  32'h8C22_0004, 1'b0, 0);
        applyStimulus("sw",  32'hAC22_0004, 1'b0, 0);
        applyStimulus("beq", 32'h1022_0003, 1'b1, 0);
        applyStimulus("beq", 32'h1022_0003, 1'b0, 0);
        applyStimulus("jal", 32'h0C00_0C00, 1'b0, 0);
        applyStimulus("jr",  32'h03E0_0008, 1'b0, 0);
        applyStimulus("nop", 32'h0000_0000, 1'b0, 0);
        applyStimulus("ill", 32'hFC00_0000, 1'b0, 0);
        applyStimulus("ill", 32'h0022_182A, 1'b0, 0);
        applyStimulus("beq", 32'h1022_0003, 1'b1, 0);
        applyStimulus("add", 32'h0022_1820, 1'b0, 0);
`ifdef MC_MEM_WAIT_EN
        applyStimulus("sw",  32'hAC22_0004, 1'b0, 3);
        applyStimulus("lw",  32'h8C22_0004, 1'b0, 2);
        applyStimulus("add", 32'h0022_1820, 1'b0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
